// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: drives the data-memory handshake, lane-aligns
// store data and byte enables, and extends load data; flags misaligned and timed-out accesses.
module mem_access_ctrl #(
  parameter int NB_DATA        = 32,
  parameter int NB_ADDR        = 32,
  parameter int NB_MASK        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req_valid,
  input  logic               i_req_write,
  input  logic [NB_ADDR-1:0] i_req_addr,
  input  logic [NB_DATA-1:0] i_req_wdata,
  input  logic [NB_MASK-1:0] i_req_mask,
  input  logic               i_req_unsigned,
  output logic               o_req_ready,
  output logic               o_stall,
  output logic               o_rsp_valid,
  output logic [NB_DATA-1:0] o_rsp_data,
  output logic               o_misaligned,
  output logic               o_timeout,
  output logic               o_mem_valid,
  output logic               o_mem_write,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  output logic [3:0]         o_mem_be,
  input  logic               i_mem_ready,
  input  logic               i_mem_rvalid,
  input  logic [NB_DATA-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_valid_q, mem_valid_d;
  logic               mem_write_q, mem_write_d;
  logic [NB_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [NB_DATA-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [NB_DATA-1:0] rsp_data_q, rsp_data_d;
  logic               misaligned_q, misaligned_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         ld_off_q, ld_off_d;
  logic [NB_MASK-1:0] ld_mask_q, ld_mask_d;
  logic               ld_uns_q, ld_uns_d;

  logic               req_misaligned;
  logic [3:0]         req_be;
  logic [NB_DATA-1:0] req_wdata;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [NB_DATA-1:0] ld_ext;

  assign req_misaligned = ((i_req_mask == NB_MASK'(1)) && i_req_addr[0]) ||
                          (i_req_mask[1] && (i_req_addr[1:0] != 2'b00));

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = i_req_wdata;
    case (i_req_mask)
      NB_MASK'(0): begin
        req_be    = 4'b0001 << i_req_addr[1:0];
        req_wdata = {(NB_DATA/8){i_req_wdata[7:0]}};
      end
      NB_MASK'(1): begin
        req_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {(NB_DATA/16){i_req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!i_req_write) req_be = 4'b1111;
  end

  // Lane select uses the offset captured at accept, not the live request bus.
  always_comb begin
    ld_byte = i_mem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half = i_mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
    case (ld_mask_q)
      NB_MASK'(0): ld_ext = ld_uns_q ? {{(NB_DATA-8){1'b0}}, ld_byte}
                                     : {{(NB_DATA-8){ld_byte[7]}}, ld_byte};
      NB_MASK'(1): ld_ext = ld_uns_q ? {{(NB_DATA-16){1'b0}}, ld_half}
                                     : {{(NB_DATA-16){ld_half[15]}}, ld_half};
      default:     ld_ext = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;
    ld_off_d     = ld_off_q;
    ld_mask_d    = ld_mask_q;
    ld_uns_d     = ld_uns_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          ld_off_d  = i_req_addr[1:0];
          ld_mask_d = i_req_mask;
          ld_uns_d  = i_req_unsigned;
          if (req_misaligned) begin
            state_d      = DONE;
            rsp_valid_d  = 1'b1;
            rsp_data_d   = '0;
            misaligned_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_write_d = i_req_write;
            mem_addr_d  = {i_req_addr[NB_ADDR-1:2], 2'b00};
            mem_wdata_d = req_wdata;
            mem_be_d    = req_be;
          end
        end
      end
      ISSUE, WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Timeout wins over a handshake landing in the same cycle.
        if (cnt_q == CNT_MAX) begin
          state_d     = DONE;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          timeout_d   = 1'b1;
        end else if (state_q == ISSUE) begin
          if (i_mem_ready) begin
            mem_valid_d = 1'b0;
            if (mem_write_q) begin
              state_d     = DONE;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
            end else begin
              state_d = WAIT;
            end
          end
        end else if (i_mem_rvalid) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ld_ext;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= 4'b0000;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      ld_off_q     <= 2'b00;
      ld_mask_q    <= '0;
      ld_uns_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
      ld_off_q     <= ld_off_d;
      ld_mask_q    <= ld_mask_d;
      ld_uns_q     <= ld_uns_d;
    end
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_stall      = ((state_q == IDLE) && i_req_valid) || (state_q == ISSUE) || (state_q == WAIT);
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_misaligned = misaligned_q;
  assign o_timeout    = timeout_q;
  assign o_mem_valid  = mem_valid_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_mem_be     = mem_be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized
// load/store traffic compared against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int T = 8;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_req_valid, i_req_write, i_req_unsigned;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [1:0]  i_req_mask;
  logic        o_req_ready, o_stall, o_rsp_valid, o_misaligned, o_timeout;
  logic [31:0] o_rsp_data;
  logic        o_mem_valid, o_mem_write;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_access_ctrl #(.NB_DATA(32), .NB_ADDR(32), .NB_MASK(2), .TIMEOUT_CYCLES(T)) dut (
    .i_clock(clock), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_mask(i_req_mask), .i_req_unsigned(i_req_unsigned),
    .o_req_ready(o_req_ready), .o_stall(o_stall), .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data), .o_misaligned(o_misaligned), .o_timeout(o_timeout),
    .o_mem_valid(o_mem_valid), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clock = ~clock;

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model: access rules expressed as plain arithmetic on the request.
  function automatic bit refMisaligned(input logic [1:0] mask, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (mask == 2'd1) return (a % 2) != 0;
    if (mask >= 2'd2) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] refBe(input bit wr, input logic [1:0] mask, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (!wr || mask >= 2'd2) return 4'hF;
    if (mask == 2'd0) return 4'(1 << a);
    return (a >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] refWdata(input logic [1:0] mask, input logic [31:0] wd);
    if (mask == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (mask == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] mask, input bit uns,
                                          input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int a;
    a = int'(addr % 4);
    if (mask == 2'd0) begin
      v = (rd >> (8 * a)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (mask == 2'd1) begin
      v = (rd >> (16 * (a / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One full transaction: the bench plays the memory (ready after rdly issue
  // cycles, rvalid after wdly wait cycles) and checks against the model.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] mask, input bit uns, input int rdly, input int wdly,
                               input bit noReady, input bit noRvalid, input logic [31:0] rdata);
    bit mis, expTo, gotRsp, handshook, firstIssue;
    int expDone, expIssue, cyc, doneCyc, issueCnt, waitCnt;
    logic [31:0] expData;
    mis   = refMisaligned(mask, addr);
    expTo = !mis && (noReady || (!wr && noRvalid));
    if (mis)        expDone = 1;
    else if (expTo) expDone = T + 2;
    else if (wr)    expDone = rdly + 2;
    else            expDone = rdly + wdly + 3;
    if (mis)          expIssue = 0;
    else if (noReady) expIssue = T + 1;
    else              expIssue = rdly + 1;
    expData = (mis || wr || expTo) ? 32'h0 : refLoad(mask, uns, addr, rdata);

    @(negedge clock);
    i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr; i_req_wdata = wdata;
    i_req_mask = mask; i_req_unsigned = uns;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    #1;
    checkOutput("ready_c0", {31'b0, o_req_ready}, 32'd1);
    checkOutput("stall_c0", {31'b0, o_stall}, 32'd1);

    cyc = 0; doneCyc = -1; gotRsp = 0; handshook = 0; firstIssue = 1; issueCnt = 0; waitCnt = 0;
    while (!gotRsp && cyc < T + 20) begin
      @(negedge clock);
      cyc++;
      i_req_valid = 1'b0; i_req_addr = $urandom; i_req_wdata = $urandom;
      i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = $urandom;
      if (o_rsp_valid) begin
        gotRsp = 1; doneCyc = cyc;
        checkOutput("rsp_data", o_rsp_data, expData);
        checkOutput("misaligned", {31'b0, o_misaligned}, {31'b0, mis});
        checkOutput("timeout", {31'b0, o_timeout}, {31'b0, expTo});
        checkOutput("ready_done", {31'b0, o_req_ready}, 32'd0);
        checkOutput("stall_done", {31'b0, o_stall}, 32'd0);
      end else begin
        checkOutput("stall_busy", {31'b0, o_stall}, 32'd1);
        checkOutput("ready_busy", {31'b0, o_req_ready}, 32'd0);
        if (o_mem_valid) begin
          issueCnt++;
          if (firstIssue) begin
            firstIssue = 0;
            checkOutput("mem_addr", o_mem_addr, addr & 32'hFFFF_FFFC);
            checkOutput("mem_write", {31'b0, o_mem_write}, {31'b0, wr});
            checkOutput("mem_be", {28'b0, o_mem_be}, {28'b0, refBe(wr, mask, addr)});
            if (wr) checkOutput("mem_wdata", o_mem_wdata, refWdata(mask, wdata));
          end
          if (!noReady && issueCnt > rdly) begin
            i_mem_ready = 1'b1;
            handshook   = 1;
          end else begin
            i_mem_rvalid = 1'($urandom_range(0, 1));
          end
        end else if (handshook && !wr) begin
          if (!noRvalid && waitCnt == wdly) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rdata;
          end
          waitCnt++;
        end
      end
    end
    checkOutput("rsp_seen", {31'b0, gotRsp}, 32'd1);
    checkOutput("latency", doneCyc, expDone);
    checkOutput("issue_cycles", issueCnt, expIssue);
    @(negedge clock);
    checkOutput("rsp_pulse", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("rsp_hold", o_rsp_data, expData);
    checkOutput("ready_after", {31'b0, o_req_ready}, 32'd1);
  endtask

  // Drops reset in the middle of a load (ISSUE or WAIT) and checks the outputs
  // collapse immediately and no response escapes afterwards.
  task automatic abortWithReset(input bit inIssue);
    @(negedge clock);
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h0000_5000;
    i_req_mask = 2'd2; i_req_unsigned = 1'b0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    @(negedge clock);
    i_req_valid = 1'b0;
    if (!inIssue) i_mem_ready = 1'b1;
    @(negedge clock);
    i_mem_ready = 1'b0;
    @(negedge clock);
    checkOutput("pre_reset_valid", {31'b0, o_mem_valid}, {31'b0, inIssue});
    #2 i_reset = 1'b0;
    #1;
    checkOutput("rst_mem_valid", {31'b0, o_mem_valid}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("rst_ready", {31'b0, o_req_ready}, 32'd1);
    checkOutput("rst_stall", {31'b0, o_stall}, 32'd0);
    checkOutput("rst_be", {28'b0, o_mem_be}, 32'd0);
    checkOutput("rst_rsp_data", o_rsp_data, 32'd0);
    checkOutput("rst_mem_addr", o_mem_addr, 32'd0);
    @(negedge clock);
    i_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      i_mem_rvalid = 1'b1;
      checkOutput("post_reset_rsp", {31'b0, o_rsp_valid}, 32'd0);
    end
    i_mem_rvalid = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0;
    i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_mask = '0; i_req_unsigned = 1'b0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_ready", {31'b0, o_req_ready}, 32'd1);
    checkOutput("reset_mem_valid", {31'b0, o_mem_valid}, 32'd0);
    checkOutput("reset_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("reset_be", {28'b0, o_mem_be}, 32'd0);
    checkOutput("reset_stall", {31'b0, o_stall}, 32'd0);
    i_reset = 1'b1;
    @(negedge clock);

    applyStimulus(0, 32'h0000_1003, 32'h0, 2'd0, 0, 0, 0, 0, 0, 32'h80FF_0000);
    applyStimulus(0, 32'h0000_2002, 32'h0, 2'd1, 1, 3, 0, 0, 0, 32'hBEEF_1234);
    applyStimulus(1, 32'h0000_3001, 32'h1234_56A5, 2'd0, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 32'h0000_3002, 32'h9876_BEEF, 2'd1, 0, 1, 0, 0, 0, 32'h0);
    applyStimulus(1, 32'h0000_3004, 32'hCAFE_F00D, 2'd3, 0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 32'h0000_4002, 32'h0, 2'd2, 0, 0, 0, 0, 0, 32'h1111_2222);
    applyStimulus(0, 32'h0000_4001, 32'h0, 2'd1, 1, 0, 0, 0, 0, 32'h1111_2222);

    applyStimulus(0, 32'h0000_6000, 32'h0, 2'd2, 0, 1, 0, 0, 1, 32'h0);
    @(negedge clock);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    i_mem_rvalid = 1'b0;
    checkOutput("late_rvalid_rsp", {31'b0, o_rsp_valid}, 32'd0);
    checkOutput("late_rvalid_ready", {31'b0, o_req_ready}, 32'd1);
    applyStimulus(0, 32'h0000_6001, 32'h0, 2'd0, 1, 0, 1, 0, 0, 32'h0000_9A00);
    applyStimulus(1, 32'h0000_7000, 32'h5555_AAAA, 2'd2, 0, 0, 0, 1, 0, 32'h0);

    abortWithReset(1'b0);
    applyStimulus(0, 32'h0000_8002, 32'h0, 2'd1, 0, 0, 0, 0, 0, 32'h8001_7FFF);
    abortWithReset(1'b1);
    applyStimulus(0, 32'h0000_8000, 32'h0, 2'd2, 0, 1, 2, 0, 0, 32'h0BAD_F00D);

    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                    0, 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
